tx_stream_sched: RTL and testbench

Packet-level scheduler sharing one AXI4-Stream master port between two requesters: the local packet generator (port 0) and the RX loopback path (port 1). Grants whole packets round-robin, never interleaves beats of different packets, and inserts a programmable idle gap after every packet. Sits between the generator/RX queues and the output datapath; per-port packet counters are exported for the register block.

---
 rtl/tx_sched_pkg.sv | 16 +
 rtl/tx_sched_pkt_cntr.sv | 25 ++
 rtl/tx_stream_sched.sv | 171 +++++++++++++++++
 tb/tb_tx_stream_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the two-port transmit packet scheduler:
// FSM encodings, port indices and the packet-counter width.
package tx_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'b001,
      ST_PASS = 3'b010,
      ST_GAP  = 3'b100
   } sched_state_t;

   localparam logic PORT_GEN  = 1'b0;
   localparam logic PORT_LOOP = 1'b1;

   localparam int CNTR_WIDTH = 32;

endpackage

// File: rtl/tx_sched_pkt_cntr.sv
// Completed-packet counter for one scheduler port; a clear in the same
// cycle as an increment leaves the counter at zero.
module tx_sched_pkt_cntr
   import tx_sched_pkg::*;
(
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESET,
   input  logic                  inc,
   input  logic                  clr,
   output logic [CNTR_WIDTH-1:0] count
);

   localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/tx_stream_sched.sv
// Whole-packet round-robin scheduler sharing one AXI4-Stream master between
// the packet generator (port 0) and the RX loopback path (port 1).
module tx_stream_sched
   import tx_sched_pkg::*;
#(
   parameter int C_AXIS_DATA_WIDTH  = 64,
   parameter int C_AXIS_TUSER_WIDTH = 128,
   parameter int C_GAP_WIDTH        = 8
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESET,

   input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_0_TDATA,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_0_TSTRB,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_0_TUSER,
   input  logic                            S_AXIS_0_TVALID,
   input  logic                            S_AXIS_0_TLAST,
   output logic                            S_AXIS_0_TREADY,

   input  logic [C_AXIS_DATA_WIDTH-1:0]    S_AXIS_1_TDATA,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_1_TSTRB,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_1_TUSER,
   input  logic                            S_AXIS_1_TVALID,
   input  logic                            S_AXIS_1_TLAST,
   output logic                            S_AXIS_1_TREADY,

   output logic [C_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                            M_AXIS_TVALID,
   output logic                            M_AXIS_TLAST,
   input  logic                            M_AXIS_TREADY,

   input  logic [1:0]                      cfg_enable,
   input  logic [C_GAP_WIDTH-1:0]          cfg_gap,
   input  logic                            clr_cntrs,

   output logic [CNTR_WIDTH-1:0]           pkt_cnt_0,
   output logic [CNTR_WIDTH-1:0]           pkt_cnt_1,
   output logic                            grant,
   output logic                            busy,
   output logic [2:0]                      dbg_state
);

   localparam logic [C_GAP_WIDTH-1:0] GAP_ONE = {{(C_GAP_WIDTH-1){1'b0}}, 1'b1};

   sched_state_t             state_q, state_d;
   logic                     grant_q, grant_d;
   logic                     last_port_q, last_port_d;
   logic [C_GAP_WIDTH-1:0]   gap_q, gap_d;
   logic [1:0]               elig;
   logic                     pkt_done;
   logic                     inc_0, inc_1;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state_q     <= ST_IDLE;
         grant_q     <= PORT_GEN;
         last_port_q <= PORT_LOOP;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_port_q <= last_port_d;
         gap_q       <= gap_d;
      end
   end

   // A beat moves on any edge where TVALID and TREADY are both high; TVALID
   // from the scheduler never looks at M_AXIS_TREADY, and a source's TREADY
   // is only ever a copy of M_AXIS_TREADY while that source holds the grant.
   always_comb begin
      M_AXIS_TDATA    = '0;
      M_AXIS_TSTRB    = '0;
      M_AXIS_TUSER    = '0;
      M_AXIS_TVALID   = 1'b0;
      M_AXIS_TLAST    = 1'b0;
      S_AXIS_0_TREADY = 1'b0;
      S_AXIS_1_TREADY = 1'b0;
      if (state_q == ST_PASS) begin
         if (grant_q == PORT_LOOP) begin
            M_AXIS_TDATA    = S_AXIS_1_TDATA;
            M_AXIS_TSTRB    = S_AXIS_1_TSTRB;
            M_AXIS_TUSER    = S_AXIS_1_TUSER;
            M_AXIS_TVALID   = S_AXIS_1_TVALID;
            M_AXIS_TLAST    = S_AXIS_1_TLAST;
            S_AXIS_1_TREADY = M_AXIS_TREADY;
         end else begin
            M_AXIS_TDATA    = S_AXIS_0_TDATA;
            M_AXIS_TSTRB    = S_AXIS_0_TSTRB;
            M_AXIS_TUSER    = S_AXIS_0_TUSER;
            M_AXIS_TVALID   = S_AXIS_0_TVALID;
            M_AXIS_TLAST    = S_AXIS_0_TLAST;
            S_AXIS_0_TREADY = M_AXIS_TREADY;
         end
      end
   end

   always_comb begin
      elig     = cfg_enable & {S_AXIS_1_TVALID, S_AXIS_0_TVALID};
      pkt_done = (state_q == ST_PASS) & M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;
      inc_0    = pkt_done & (grant_q == PORT_GEN);
      inc_1    = pkt_done & (grant_q == PORT_LOOP);
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_port_d = last_port_q;
      gap_d       = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (elig != 2'b00) begin
               state_d = ST_PASS;
               // Contention goes to whichever port did not send the last packet.
               if (elig == 2'b11) begin
                  grant_d = ~last_port_q;
               end else begin
                  grant_d = elig[1];
               end
            end
         end
         ST_PASS: begin
            if (pkt_done) begin
               last_port_d = grant_q;
               if (cfg_gap == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_d   = cfg_gap;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q <= GAP_ONE) begin
               gap_d   = '0;
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q - GAP_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gap_d   = '0;
         end
      endcase
   end

   always_comb begin
      grant     = grant_q;
      busy      = (state_q == ST_PASS) || (state_q == ST_GAP);
      dbg_state = state_q;
   end

   tx_sched_pkt_cntr u_cntr_0 (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESET (S_AXI_ARESET),
      .inc          (inc_0),
      .clr          (clr_cntrs),
      .count        (pkt_cnt_0)
   );

   tx_sched_pkt_cntr u_cntr_1 (
      .S_AXI_ACLK   (S_AXI_ACLK),
      .S_AXI_ARESET (S_AXI_ARESET),
      .inc          (inc_1),
      .clr          (clr_cntrs),
      .count        (pkt_cnt_1)
   );

endmodule

// File: tb/tb_tx_stream_sched.sv
// Directed bench for tx_stream_sched: per-cycle vector tables plus
// hand-written sequences for arbitration order and mid-packet reset.
module tb_tx_stream_sched;

   logic          clk;
   logic          rst;
   logic [63:0]   s0_tdata, s1_tdata, m_tdata;
   logic [7:0]    s0_tstrb, s1_tstrb, m_tstrb;
   logic [127:0]  s0_tuser, s1_tuser, m_tuser;
   logic          s0_tvalid, s0_tlast, s0_tready;
   logic          s1_tvalid, s1_tlast, s1_tready;
   logic          m_tvalid, m_tlast, m_tready;
   logic [1:0]    cfg_enable;
   logic [7:0]    cfg_gap;
   logic          clr_cntrs;
   logic [31:0]   pkt_cnt_0, pkt_cnt_1;
   logic          grant, busy;
   logic [2:0]    dbg_state;

   int checks = 0;
   int errors = 0;

   localparam logic [63:0] Z = 64'h0;

   tx_stream_sched dut (
      .S_AXI_ACLK      (clk),
      .S_AXI_ARESET    (rst),
      .S_AXIS_0_TDATA  (s0_tdata),
      .S_AXIS_0_TSTRB  (s0_tstrb),
      .S_AXIS_0_TUSER  (s0_tuser),
      .S_AXIS_0_TVALID (s0_tvalid),
      .S_AXIS_0_TLAST  (s0_tlast),
      .S_AXIS_0_TREADY (s0_tready),
      .S_AXIS_1_TDATA  (s1_tdata),
      .S_AXIS_1_TSTRB  (s1_tstrb),
      .S_AXIS_1_TUSER  (s1_tuser),
      .S_AXIS_1_TVALID (s1_tvalid),
      .S_AXIS_1_TLAST  (s1_tlast),
      .S_AXIS_1_TREADY (s1_tready),
      .M_AXIS_TDATA    (m_tdata),
      .M_AXIS_TSTRB    (m_tstrb),
      .M_AXIS_TUSER    (m_tuser),
      .M_AXIS_TVALID   (m_tvalid),
      .M_AXIS_TLAST    (m_tlast),
      .M_AXIS_TREADY   (m_tready),
      .cfg_enable      (cfg_enable),
      .cfg_gap         (cfg_gap),
      .clr_cntrs       (clr_cntrs),
      .pkt_cnt_0       (pkt_cnt_0),
      .pkt_cnt_1       (pkt_cnt_1),
      .grant           (grant),
      .busy            (busy),
      .dbg_state       (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0]  sin;   // {s0_tvalid, s0_tlast, s1_tvalid, s1_tlast}
      logic [63:0] s0d;
      logic [63:0] s1d;
      logic        mr;
      logic [1:0]  en;
      logic [7:0]  gap;
      logic        clr;
      logic [5:0]  eout;  // {m_tvalid, m_tlast, s0_tready, s1_tready, grant, busy}
      logic [63:0] ed;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] sin, input logic [63:0] s0d,
                               input logic [63:0] s1d, input logic mr,
                               input logic [1:0] en, input logic [7:0] gap,
                               input logic clr, input logic [5:0] eout,
                               input logic [63:0] ed);
      vec_t v;
      v.sin = sin; v.s0d = s0d; v.s1d = s1d; v.mr = mr; v.en = en;
      v.gap = gap; v.clr = clr; v.eout = eout; v.ed = ed;
      return v;
   endfunction

   // ---------------- scoreboard ----------------
   logic [65:0] exp_q[$];   // {grant, tlast, tdata}
   logic        mon_en = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [65:0] e;
      #3;
      if (mon_en && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_beat: got %0h, want no beat", {grant, m_tlast, m_tdata});
         end else begin
            e = exp_q.pop_front();
            check("sb_beat", {62'h0, grant, m_tlast, m_tdata}, {62'h0, e});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_port(input bit p, input logic v, input logic l, input logic [63:0] d);
      if (p) begin
         s1_tvalid = v; s1_tlast = l; s1_tdata = d; s1_tuser = {d, ~d};
      end else begin
         s0_tvalid = v; s0_tlast = l; s0_tdata = d; s0_tuser = {d, ~d};
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_port(1'b0, 1'b0, 1'b0, Z);
      drive_port(1'b1, 1'b0, 1'b0, Z);
      clr_cntrs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_pkt(input bit p, input int nb, input logic [63:0] base);
      int waited;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         drive_port(p, 1'b1, (i == nb - 1), base + 64'(i));
         #1;
         waited = 0;
         while (!(p ? s1_tready : s0_tready) && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
         end
         if (waited >= 200) begin
            checks++;
            errors++;
            $display("FAIL src%0d_timeout: got no TREADY, want TREADY within 200 cycles", p);
            return;
         end
      end
   endtask

   task automatic src(input bit p, input logic [63:0] b0, input logic [63:0] b1);
      send_pkt(p, 2, b0);
      send_pkt(p, 2, b1);
      @(negedge clk);
      drive_port(p, 1'b0, 1'b0, Z);
   endtask

   task automatic run_table(input string tag);
      vec_t v;
      logic [7:0]   estrb;
      logic [127:0] euser;
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive_port(1'b0, v.sin[3], v.sin[2], v.s0d);
         drive_port(1'b1, v.sin[1], v.sin[0], v.s1d);
         m_tready   = v.mr;
         cfg_enable = v.en;
         cfg_gap    = v.gap;
         clr_cntrs  = v.clr;
         #1;
         estrb = v.eout[5] ? (v.eout[1] ? 8'h0F : 8'hFF) : 8'h00;
         euser = v.eout[5] ? {v.ed, ~v.ed} : 128'h0;
         check($sformatf("%s[%0d].tvalid", tag, i), m_tvalid, v.eout[5]);
         check($sformatf("%s[%0d].tlast", tag, i), m_tlast, v.eout[4]);
         check($sformatf("%s[%0d].tdata", tag, i), m_tdata, v.eout[5] ? v.ed : Z);
         check($sformatf("%s[%0d].tstrb", tag, i), m_tstrb, estrb);
         check($sformatf("%s[%0d].tuser", tag, i), m_tuser, euser);
         check($sformatf("%s[%0d].s0_ready", tag, i), s0_tready, v.eout[3]);
         check($sformatf("%s[%0d].s1_ready", tag, i), s1_tready, v.eout[2]);
         check($sformatf("%s[%0d].grant", tag, i), grant, v.eout[1]);
         check($sformatf("%s[%0d].busy", tag, i), busy, v.eout[0]);
      end
      vecs.delete();
      @(negedge clk);
      clr_cntrs = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      rst = 1'b1;
      s0_tstrb = 8'hFF;
      s1_tstrb = 8'h0F;
      drive_port(1'b0, 1'b0, 1'b0, Z);
      drive_port(1'b1, 1'b0, 1'b0, Z);
      m_tready = 1'b1; cfg_enable = 2'b11; cfg_gap = 8'd0; clr_cntrs = 1'b0;

      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst.tvalid", m_tvalid, 1'b0);
      check("rst.s0_ready", s0_tready, 1'b0);
      check("rst.s1_ready", s1_tready, 1'b0);
      check("rst.busy", busy, 1'b0);
      check("rst.grant", grant, 1'b0);
      check("rst.cnt0", pkt_cnt_0, 32'd0);
      check("rst.cnt1", pkt_cnt_1, 32'd0);
      check("rst.state", dbg_state, 3'b001);
      rst = 1'b0;

      // port 0 only, 3-beat packet
      vecs.push_back(mk(4'b1000, 64'hA0, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b1000, 64'hA0, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b101001, 64'hA0));
      vecs.push_back(mk(4'b1000, 64'hA1, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b101001, 64'hA1));
      vecs.push_back(mk(4'b1100, 64'hA2, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b111001, 64'hA2));
      vecs.push_back(mk(4'b0000, Z, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b000000, Z));
      run_table("p0_3beat");
      check("p0_3beat.cnt0", pkt_cnt_0, 32'd1);
      check("p0_3beat.cnt1", pkt_cnt_1, 32'd0);

      // port 1, 4-beat packet, M_AXIS_TREADY toggling 0,1,0,1...
      vecs.push_back(mk(4'b0010, Z, 64'hB0, 1'b1, 2'b11, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b0010, Z, 64'hB0, 1'b0, 2'b11, 8'd0, 1'b0, 6'b100011, 64'hB0));
      vecs.push_back(mk(4'b0010, Z, 64'hB0, 1'b1, 2'b11, 8'd0, 1'b0, 6'b100111, 64'hB0));
      vecs.push_back(mk(4'b0010, Z, 64'hB1, 1'b0, 2'b11, 8'd0, 1'b0, 6'b100011, 64'hB1));
      vecs.push_back(mk(4'b0010, Z, 64'hB1, 1'b1, 2'b11, 8'd0, 1'b0, 6'b100111, 64'hB1));
      vecs.push_back(mk(4'b0010, Z, 64'hB2, 1'b0, 2'b11, 8'd0, 1'b0, 6'b100011, 64'hB2));
      vecs.push_back(mk(4'b0010, Z, 64'hB2, 1'b1, 2'b11, 8'd0, 1'b0, 6'b100111, 64'hB2));
      vecs.push_back(mk(4'b0011, Z, 64'hB3, 1'b0, 2'b11, 8'd0, 1'b0, 6'b110011, 64'hB3));
      vecs.push_back(mk(4'b0011, Z, 64'hB3, 1'b1, 2'b11, 8'd0, 1'b0, 6'b110111, 64'hB3));
      vecs.push_back(mk(4'b0000, Z, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b000010, Z));
      run_table("p1_toggle");
      check("p1_toggle.cnt0", pkt_cnt_0, 32'd1);
      check("p1_toggle.cnt1", pkt_cnt_1, 32'd1);

      // cfg_gap = 5 between back-to-back single-beat port 0 packets
      vecs.push_back(mk(4'b1100, 64'hC0, Z, 1'b1, 2'b11, 8'd5, 1'b0, 6'b000010, Z));
      vecs.push_back(mk(4'b1100, 64'hC0, Z, 1'b1, 2'b11, 8'd5, 1'b0, 6'b111001, 64'hC0));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(4'b1100, 64'hC1, Z, 1'b1, 2'b11, 8'd5, 1'b0, 6'b000001, Z));
      vecs.push_back(mk(4'b1100, 64'hC1, Z, 1'b1, 2'b11, 8'd5, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b1100, 64'hC1, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b111001, 64'hC1));
      vecs.push_back(mk(4'b0000, Z, Z, 1'b1, 2'b11, 8'd0, 1'b0, 6'b000000, Z));
      run_table("gap5");
      check("gap5.cnt0", pkt_cnt_0, 32'd3);

      // port 1 disabled while valid; clear coincides with port 0 TLAST
      vecs.push_back(mk(4'b0010, Z, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b0010, Z, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b1110, 64'hE0, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b1110, 64'hE0, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b1, 6'b111001, 64'hE0));
      vecs.push_back(mk(4'b0010, Z, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b0, 6'b000000, Z));
      vecs.push_back(mk(4'b0010, Z, 64'hD0, 1'b1, 2'b01, 8'd0, 1'b0, 6'b000000, Z));
      run_table("en01_clr");
      check("en01_clr.cnt0", pkt_cnt_0, 32'd0);
      check("en01_clr.cnt1", pkt_cnt_1, 32'd0);

      // both ports continuously valid, 2-beat packets: grants 0,1,0,1
      do_reset();
      cfg_enable = 2'b11; cfg_gap = 8'd0; m_tready = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 64'h100});
      exp_q.push_back({1'b0, 1'b1, 64'h101});
      exp_q.push_back({1'b1, 1'b0, 64'h200});
      exp_q.push_back({1'b1, 1'b1, 64'h201});
      exp_q.push_back({1'b0, 1'b0, 64'h110});
      exp_q.push_back({1'b0, 1'b1, 64'h111});
      exp_q.push_back({1'b1, 1'b0, 64'h210});
      exp_q.push_back({1'b1, 1'b1, 64'h211});
      mon_en = 1'b1;
      fork
         src(1'b0, 64'h100, 64'h110);
         src(1'b1, 64'h200, 64'h210);
      join
      repeat (4) @(negedge clk);
      mon_en = 1'b0;
      check("rr.drained", 128'(exp_q.size()), 128'd0);
      check("rr.cnt0", pkt_cnt_0, 32'd2);
      check("rr.cnt1", pkt_cnt_1, 32'd2);

      // reset asserted mid-packet
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b0, 64'hF0);
      @(negedge clk);
      @(negedge clk);
      drive_port(1'b0, 1'b1, 1'b0, 64'hF1);
      #1;
      check("mid.tvalid_before", m_tvalid, 1'b1);
      #2;
      rst = 1'b1;
      drive_port(1'b1, 1'b1, 1'b0, 64'h300);
      #1;
      check("mid.tvalid", m_tvalid, 1'b0);
      check("mid.s0_ready", s0_tready, 1'b0);
      check("mid.s1_ready", s1_tready, 1'b0);
      check("mid.busy", busy, 1'b0);
      check("mid.cnt0", pkt_cnt_0, 32'd0);
      check("mid.cnt1", pkt_cnt_1, 32'd0);
      check("mid.state", dbg_state, 3'b001);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post.idle_tvalid", m_tvalid, 1'b0);
      @(negedge clk);
      #1;
      check("post.tvalid", m_tvalid, 1'b1);
      check("post.grant", grant, 1'b0);
      check("post.tdata", m_tdata, 64'hF1);
      check("post.s0_ready", s0_tready, 1'b1);
      check("post.s1_ready", s1_tready, 1'b0);
      drive_port(1'b0, 1'b0, 1'b0, Z);
      drive_port(1'b1, 1'b0, 1'b0, Z);
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
